// File: rtl/uart_rx_stream.sv
// 8N1 UART receiver: 2-FF synchroniser, mid-bit sampling FSM and a small FWFT FIFO
// presenting received bytes as a valid/ready stream with framing/overrun pulses.
module uart_rx_stream #(
    parameter int CLK_DIV = 104,
    parameter int FIFO_AW = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_frame_err,
    output logic       o_overrun
);

    localparam int CW = $clog2(CLK_DIV) + 1;
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [CW-1:0] HALF_M1 = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t state, state_nxt;

    logic          rx_m, rx_s;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          tick;
    logic          push_req, ferr_set, sample_bit;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= i_rx;
            rx_s <= rx_m;
        end
    end

    assign tick = (cnt == '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (!rx_s) state_nxt = ST_START;
            ST_START: if (tick) state_nxt = rx_s ? ST_IDLE : ST_DATA;
            ST_DATA:  if (tick && bit_idx == 3'd7) state_nxt = ST_STOP;
            ST_STOP:  if (tick) state_nxt = rx_s ? ST_IDLE : ST_BREAK;
            ST_BREAK: if (rx_s) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        push_req   = 1'b0;
        ferr_set   = 1'b0;
        sample_bit = 1'b0;
        case (state)
            ST_DATA: sample_bit = tick;
            ST_STOP: begin
                push_req = tick && rx_s;
                ferr_set = tick && !rx_s;
            end
            default: ;
        endcase
    end

    // IDLE preloads a half bit so every later expiry lands mid-bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt     <= HALF_M1;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if (state == ST_IDLE) begin
                cnt     <= HALF_M1;
                bit_idx <= '0;
            end else if (tick) begin
                cnt <= FULL_M1;
            end else begin
                cnt <= cnt - CW'(1);
            end
            if (sample_bit) begin
                shreg   <= {rx_s, shreg[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

    // Stream handshake: o_valid/o_data hold until o_valid && i_ready at a clock
    // edge; o_valid never depends combinationally on i_ready.
    logic [7:0]       mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr, rd_ptr;
    logic             empty, full, pop, push;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                   (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign pop   = !empty && i_ready;
    assign push  = push_req && (!full || pop);

    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr[FIFO_AW-1:0]] <= shreg;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            o_frame_err <= ferr_set;
            o_overrun   <= push_req && full && !pop;
        end
    end

    assign o_data  = mem[rd_ptr[FIFO_AW-1:0]];
    assign o_valid = !empty;

endmodule

// File: tb/tb_uart_rx_stream.sv
// Directed and randomized bench for uart_rx_stream: drives 8N1 frames, records the
// byte stream and pulses, and compares them with timing derived from bit-period arithmetic.
`timescale 1ns/1ps
module tb_uart_rx_stream;

    localparam int D  = 8;
    localparam int AW = 2;
    localparam int H  = D / 2;
    localparam int STOP_OFS = 2 + H + 9 * D;

    logic       clk = 1'b0;
    logic       i_rst_n, i_rx, i_ready;
    logic [7:0] o_data;
    logic       o_valid, o_frame_err, o_overrun;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int valid_cycles, ferr_n, ovr_n, ferr_cyc, ovr_cyc;
    int s, s5;
    bit rnd_ready = 1'b0;
    logic [7:0] b;
    logic [7:0] got_q[$];
    int         got_cyc_q[$];
    logic [7:0] exp_q[$];

    uart_rx_stream #(.CLK_DIV(D), .FIFO_AW(AW)) dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_rx(i_rx), .o_data(o_data), .o_valid(o_valid),
        .i_ready(i_ready), .o_frame_err(o_frame_err), .o_overrun(o_overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rnd_ready) i_ready = ($urandom_range(0, 3) != 0);
    end

    always @(negedge clk) begin
        if (i_rst_n) begin
            if (o_valid && i_ready) begin
                got_q.push_back(o_data);
                got_cyc_q.push_back(cyc);
            end
            if (o_valid) valid_cycles++;
            if (o_frame_err) begin ferr_n++; ferr_cyc = cyc; end
            if (o_overrun) begin ovr_n++; ovr_cyc = cyc; end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        got_q.delete();
        got_cyc_q.delete();
        exp_q.delete();
        valid_cycles = 0;
        ferr_n = 0;
        ovr_n = 0;
    endtask

    // Line is left at the stop level so a caller can extend a low stop into a break.
    task automatic send_frame(input logic [7:0] data, input logic stop);
        i_rx = 1'b0;
        wait_cyc(D);
        for (int k = 0; k < 8; k++) begin
            i_rx = data[k];
            wait_cyc(D);
        end
        i_rx = stop;
        wait_cyc(D);
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk(tag, (i < got_q.size()) ? 32'(got_q[i]) : 32'hxxxxxxxx, 32'(exp_q[i]));
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_rx    = 1'b1;
        i_ready = 1'b1;
        clear_mon();
        wait_cyc(3);
        chk("reset_valid", o_valid, 0);
        chk("reset_ferr", o_frame_err, 0);
        chk("reset_ovr", o_overrun, 0);
        i_rst_n = 1'b1;
        wait_cyc(5);

        // single byte with exact latency
        clear_mon();
        s = cyc;
        send_frame(8'hA3, 1'b1);
        wait_cyc(20);
        exp_q.push_back(8'hA3);
        check_stream("single");
        chk("single_latency", (got_cyc_q.size() > 0) ? got_cyc_q[0] : -1, s + STOP_OFS + 1);
        chk("single_valid_cycles", valid_cycles, 1);
        chk("single_pulses", ferr_n + ovr_n, 0);

        // short glitch is rejected, next byte unaffected
        clear_mon();
        i_rx = 1'b0;
        wait_cyc(2);
        i_rx = 1'b1;
        wait_cyc(20);
        chk("glitch_valid_cycles", valid_cycles, 0);
        chk("glitch_pulses", ferr_n + ovr_n, 0);
        send_frame(8'h5A, 1'b1);
        wait_cyc(20);
        exp_q.push_back(8'h5A);
        check_stream("after_glitch");

        // framing error followed by a held-low break
        clear_mon();
        s = cyc;
        send_frame(8'h55, 1'b0);
        wait_cyc(40);
        i_rx = 1'b1;
        wait_cyc(20);
        chk("break_ferr_count", ferr_n, 1);
        chk("break_ferr_cycle", ferr_cyc, s + STOP_OFS + 1);
        chk("break_no_byte", got_q.size(), 0);
        send_frame(8'h01, 1'b1);
        wait_cyc(20);
        exp_q.push_back(8'h01);
        check_stream("after_break");
        chk("after_break_ferr", ferr_n, 1);
        chk("after_break_ovr", ovr_n, 0);

        // overrun: five frames into a four-entry FIFO with no consumer
        clear_mon();
        i_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            s = cyc;
            if (k == 4) s5 = s;
            b = 8'h10 + 8'(k);
            if (k < (1 << AW)) exp_q.push_back(b);
            send_frame(b, 1'b1);
        end
        wait_cyc(20);
        chk("ovr_count", ovr_n, 5 - (1 << AW));
        chk("ovr_cycle", ovr_cyc, s5 + STOP_OFS + 1);
        chk("ovr_ferr", ferr_n, 0);
        i_ready = 1'b1;
        wait_cyc(10);
        check_stream("ovr_drain");
        chk("ovr_empty", o_valid, 0);

        // full FIFO with a pop in the very stop-sample cycle
        clear_mon();
        i_ready = 1'b0;
        for (int k = 0; k < (1 << AW); k++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send_frame(b, 1'b1);
        end
        exp_q.push_back(8'h77);
        fork
            send_frame(8'h77, 1'b1);
            begin
                wait_cyc(STOP_OFS);
                i_ready = 1'b1;
            end
        join
        wait_cyc(20);
        check_stream("full_pop");
        chk("full_pop_ovr", ovr_n, 0);

        // asynchronous reset mid-frame discards partial byte and FIFO contents
        clear_mon();
        i_ready = 1'b0;
        repeat (2) send_frame(8'($urandom_range(0, 255)), 1'b1);
        fork
            send_frame(8'($urandom_range(0, 255)), 1'b1);
            begin
                wait_cyc(2 + H + 3 * D + 2);
                i_rst_n = 1'b0;
                #1;
                chk("rst_async_valid", o_valid, 0);
                chk("rst_ferr", o_frame_err, 0);
                chk("rst_ovr", o_overrun, 0);
            end
        join
        wait_cyc(5);
        clear_mon();
        i_rst_n = 1'b1;
        wait_cyc(5);
        chk("rst_release_valid", o_valid, 0);
        i_ready = 1'b1;
        send_frame(8'hC5, 1'b1);
        wait_cyc(20);
        exp_q.push_back(8'hC5);
        check_stream("after_reset");
        chk("after_reset_pulses", ferr_n + ovr_n, 0);

        // random bytes, random gaps, random consumer stalls
        clear_mon();
        rnd_ready = 1'b1;
        repeat (8) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            wait_cyc($urandom_range(0, 15));
            send_frame(b, 1'b1);
        end
        wait_cyc(20);
        rnd_ready = 1'b0;
        wait_cyc(1);
        i_ready = 1'b1;
        wait_cyc(20);
        check_stream("random");
        chk("random_pulses", ferr_n + ovr_n, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
